// File: rtl/precompute_bank.sv
// Odd-multiple precompute (k*x, k = 1,3,..,15) for the coefficient-select multiplier stage.
// Two-stage valid/ready pipe with 2-cycle latency; it buffers up to two sets and stalls upstream only when both stages are full.
module precompute_bank (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [11:0] x1,
  output logic signed [11:0] x3,
  output logic signed [11:0] x5,
  output logic signed [11:0] x7,
  output logic signed [11:0] x9,
  output logic signed [11:0] x11,
  output logic signed [11:0] x13,
  output logic signed [11:0] x15
);

  typedef struct packed {
    logic signed [11:0] x1;
    logic signed [11:0] x3;
    logic signed [11:0] x5;
    logic signed [11:0] x7;
    logic signed [11:0] x9;
    logic signed [11:0] x15;
  } s1_t;

  typedef struct packed {
    logic signed [11:0] x1;
    logic signed [11:0] x3;
    logic signed [11:0] x5;
    logic signed [11:0] x7;
    logic signed [11:0] x9;
    logic signed [11:0] x11;
    logic signed [11:0] x13;
    logic signed [11:0] x15;
  } s2_t;

  logic               s1_vld;
  logic               s2_vld;
  logic               s1_load;
  logic               s2_load;
  logic signed [11:0] xe;
  s1_t                s1_dat;
  s1_t                s1_nxt;
  s2_t                s2_dat;
  s2_t                s2_nxt;

  // 12 bits hold |15*x| <= 1920 exactly, so no stage needs guard bits.
  always_comb begin
    xe         = {{4{x[7]}}, x};
    s1_nxt.x1  = xe;
    s1_nxt.x3  = (xe <<< 1) + xe;
    s1_nxt.x5  = (xe <<< 2) + xe;
    s1_nxt.x9  = (xe <<< 3) + xe;
    s1_nxt.x7  = (xe <<< 3) - xe;
    s1_nxt.x15 = (xe <<< 4) - xe;
  end

  always_comb begin
    s2_nxt.x1  = s1_dat.x1;
    s2_nxt.x3  = s1_dat.x3;
    s2_nxt.x5  = s1_dat.x5;
    s2_nxt.x7  = s1_dat.x7;
    s2_nxt.x9  = s1_dat.x9;
    s2_nxt.x11 = s1_dat.x9 + (s1_dat.x1 <<< 1);
    s2_nxt.x13 = s1_dat.x9 + (s1_dat.x1 <<< 2);
    s2_nxt.x15 = s1_dat.x15;
  end

  assign s2_load  = s1_vld && (!s2_vld || out_ready);
  assign s1_load  = in_valid && (!s1_vld || s2_load);
  assign in_ready = !s1_vld || !s2_vld || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= s1_load || (s1_vld && !s2_load);
      if (s1_load) begin
        s1_dat <= s1_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      s2_vld <= s2_load || (s2_vld && !out_ready);
      if (s2_load) begin
        s2_dat <= s2_nxt;
      end
    end
  end

  assign out_valid = s2_vld;
  assign x1        = s2_dat.x1;
  assign x3        = s2_dat.x3;
  assign x5        = s2_dat.x5;
  assign x7        = s2_dat.x7;
  assign x9        = s2_dat.x9;
  assign x11       = s2_dat.x11;
  assign x13       = s2_dat.x13;
  assign x15       = s2_dat.x15;

endmodule

// File: tb/tb_precompute_bank.sv
// Bench for precompute_bank: directed cases plus randomized valid/ready traffic against a queue-based model.
module tb_precompute_bank;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  x;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] x1, x3, x5, x7, x9, x11, x13, x15;

  int checks = 0;
  int errors = 0;

  // A set becomes visible only after spending one full edge inside the pipe.
  typedef struct {
    logic signed [7:0] v;
    bit                fresh;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  precompute_bank dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x1        (x1),
    .x3        (x3),
    .x5        (x5),
    .x7        (x7),
    .x9        (x9),
    .x11       (x11),
    .x13       (x13),
    .x15       (x15)
  );

  function automatic logic [95:0] exp_set(input logic signed [7:0] v);
    logic [95:0] r;
    int p;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      p = (2 * k + 1) * int'(v);
      r[k*12 +: 12] = p[11:0];
    end
    return r;
  endfunction

  function automatic logic [95:0] outs();
    return {x15, x13, x11, x9, x7, x5, x3, x1};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, check against the model, then advance the model at the posedge.
  task automatic step(input logic iv, input logic signed [7:0] xv, input logic ordy);
    bit ev;
    bit er;
    in_valid  = iv;
    x         = xv;
    out_ready = ordy;
    #1;
    ev = (q.size() > 0) && !q[0].fresh;
    er = (q.size() < 2) || ordy;
    chk("out_valid", {95'd0, out_valid}, {95'd0, ev});
    chk("in_ready", {95'd0, in_ready}, {95'd0, er});
    if (ev) chk("data", outs(), exp_set(q[0].v));
    @(posedge clk);
    if (ev && ordy) void'(q.pop_front());
    foreach (q[i]) q[i].fresh = 1'b0;
    if (iv && er) q.push_back('{xv, 1'b1});
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
    chk("rst_outputs", outs(), 96'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Unit sample: set 1,3,..,15 two cycles after acceptance.
    step(1'b1, 8'sd1, 1'b1);
    step(1'b0, 8'sd0, 1'b1);
    chk("x1_x7", {84'd0, x7}, 96'd7);
    chk("x1_x15", {84'd0, x15}, 96'd15);
    step(1'b0, 8'sd0, 1'b1);

    // Range extremes.
    step(1'b1, -8'sd128, 1'b1);
    step(1'b0, 8'sd0, 1'b1);
    chk("neg_x15", {84'd0, x15}, {84'd0, 12'h880});
    chk("neg_x13", {84'd0, x13}, {84'd0, 12'(-1664)});
    chk("neg_x1", {84'd0, x1}, {84'd0, 12'hF80});
    step(1'b1, 8'sd127, 1'b1);
    step(1'b0, 8'sd0, 1'b1);
    chk("pos_x15", {84'd0, x15}, 96'd1905);
    chk("pos_x11", {84'd0, x11}, 96'd1397);
    step(1'b0, 8'sd0, 1'b1);

    // Back-to-back stream.
    for (int i = 0; i <= 20; i++) step(1'b1, 8'(i), 1'b1);
    repeat (3) step(1'b0, 8'sd0, 1'b1);

    // Backpressure: 5 and 6 buffered, 7 held off, outputs frozen at 5.
    step(1'b1, 8'sd5, 1'b0);
    step(1'b1, 8'sd6, 1'b0);
    in_valid = 1'b1;
    x        = 8'sd7;
    #1;
    chk("bp_in_ready", {95'd0, in_ready}, 96'd0);
    chk("bp_x5", {84'd0, x5}, 96'd25);
    step(1'b1, 8'sd7, 1'b0);
    step(1'b1, 8'sd7, 1'b0);
    step(1'b1, 8'sd7, 1'b1);
    repeat (3) step(1'b0, 8'sd0, 1'b1);

    // Full pipe: accept and consume in the same cycle keeps occupancy at two.
    step(1'b1, 8'sd9, 1'b0);
    step(1'b1, 8'sd10, 1'b0);
    step(1'b1, 8'sd11, 1'b1);
    step(1'b0, 8'sd0, 1'b0);
    chk("shift_x1", {84'd0, x1}, 96'd10);
    repeat (3) step(1'b0, 8'sd0, 1'b1);

    // Mid-stream reset discards in-flight sets immediately.
    step(1'b1, 8'sd20, 1'b0);
    step(1'b1, 8'sd21, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("mid_rst_outputs", outs(), 96'd0);
    chk("mid_rst_in_ready", {95'd0, in_ready}, 96'd1);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'sd3, 1'b1);
    step(1'b0, 8'sd0, 1'b1);
    chk("post_rst_x15", {84'd0, x15}, 96'd45);
    repeat (3) step(1'b0, 8'sd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
    end
    repeat (4) step(1'b0, 8'sd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/precompute_bank.md
PRECOMPUTE_BANK -- requirements
Module: precompute_bank

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream sample x is valid this cycle.
REQ-005 in_ready  output  1  block accepts x this cycle; a transfer occurs when in_valid && in_ready.
REQ-006 x  input  8  signed input sample, two's complement.
REQ-007 out_valid  output  1  x1..x15 hold a valid odd-multiple set.
REQ-008 out_ready  input  1  downstream multiplier stage consumes the set; a transfer occurs when out_valid && out_ready.
REQ-009 x1, x3, x5, x7, x9, x11, x13, x15  output  12 each  signed odd multiples k*x (k = 1..15, odd) of one accepted sample, feeding the coefficient-select multiplier stage.

Function
REQ-010 The datapath SHALL be a two-stage pipeline (S1, S2), each stage with its own valid bit.
REQ-011 S1 SHALL register sign-extended x, plus x3 = (x<<1)+x, x5 = (x<<2)+x, x9 = (x<<3)+x, x7 = (x<<3)-x and x15 = (x<<4)-x, all in 12-bit signed arithmetic.
REQ-012 S2 SHALL compute x11 = x9 + (x<<1) and x13 = x9 + (x<<2) from the S1 registers, and register them together with the passed-through x1, x3, x5, x7, x9 and x15.
REQ-013 No multipliers SHALL be used; only shifts, adds and subtracts.
REQ-014 Results SHALL be exact over the full input range -128..127; no saturation or overflow is possible, since |15*x| <= 1920 < 2048.
REQ-015 Outputs x1..x15 SHALL be driven directly from S2 registers; out_valid SHALL equal the S2 valid bit.
REQ-016 S2 SHALL load from S1 when S1 is valid and S2 is empty or out_ready = 1.
REQ-017 S1 SHALL load from x when in_valid = 1 and S1 is empty or S1 is loading into S2 this cycle.
REQ-018 in_ready SHALL be combinational: !S1_valid || !S2_valid || out_ready.
REQ-019 The S2 valid bit SHALL clear when its data is consumed and no new S1 data enters that cycle.
REQ-020 The S1 valid bit SHALL clear when its data moves to S2 and no new sample is accepted that cycle.
REQ-021 Latency SHALL be exactly 2 cycles from accept edge to out_valid, with out_ready held high.
REQ-022 Throughput SHALL be 1 set per cycle with out_ready continuously high.
REQ-023 While out_valid = 1 and out_ready = 0, x1..x15 and out_valid SHALL remain stable.
REQ-024 Backpressure: with out_ready low, at most 2 sets SHALL be buffered (S2 + S1); in_ready SHALL drop only when both stages are valid.
REQ-025 Simultaneous accept and consume on a full pipe SHALL shift both stages in the same cycle, with no data lost or duplicated.
REQ-026 Sample order SHALL be preserved; no set SHALL be emitted twice or dropped.
REQ-027 When in_valid = 0, x SHALL be ignored; stage data registers MAY hold stale values while their valid bit is 0.

Reset
REQ-028 reset = 1 SHALL asynchronously clear S1_valid, S2_valid and all data registers to 0, so that out_valid = 0 and x1..x15 = 0.
REQ-029 in_ready SHALL read 1 during and immediately after reset.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight sets; no set accepted before reset SHALL appear after reset is released.
REQ-031 The first sample accepted after reset release SHALL follow REQ-021 latency exactly.

Verification
REQ-032 Accept x=1, out_ready=1 -> exactly 2 cycles later out_valid=1 with x1..x15 = 1,3,5,7,9,11,13,15.
REQ-033 Accept x=-128 -> x15 = -1920 (0x880), x13 = -1664, x1 = -128 (0xF80). Accept x=127 -> x15 = 1905, x11 = 1397.
REQ-034 Stream x = 0..20 back-to-back with out_ready=1 -> 21 consecutive out_valid cycles, in order, each output equal to k*x.
REQ-035 out_ready=0 while presenting x=5, 6, 7 -> 5 and 6 are accepted, in_ready=0 while 7 is held, outputs frozen at 5's set. Raise out_ready -> sets emitted as 5, 6, 7 with no loss.
REQ-036 Full pipe, then in_valid=1 and out_ready=1 in the same cycle -> one set out and one sample in that cycle; occupancy stays 2.
REQ-037 Assert reset with 2 sets in flight -> out_valid=0 and outputs 0 immediately (before the next clock edge). After release, accept x=3 -> only the set for x=3 (x15 = 45) appears, 2 cycles later.
